// File: rtl/wave_pkg.sv
// Shared wavetable/DAC definitions used by the NCO and the DAC reader.
package wave_pkg;

  localparam int unsigned WAVERAM_ADDR_W = 13;
  localparam int unsigned SAMPLE_W       = 12;
  localparam int unsigned DAC_FRAME_W    = 16;
  localparam int unsigned DAC_CMD_W      = DAC_FRAME_W - SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT,
    LOAD,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/wave_dac_reader_if.sv
// Wavetable RAM read port: address + one-cycle strobe out, data back one cycle later.
interface wave_dac_reader_if;
  import wave_pkg::*;

  logic [WAVERAM_ADDR_W-1:0] ram_address;
  logic                      ram_read_enable;
  logic [SAMPLE_W-1:0]       ram_data;

  modport master (
    output ram_address,
    output ram_read_enable,
    input  ram_data
  );

  modport slave (
    input  ram_address,
    input  ram_read_enable,
    output ram_data
  );

endinterface

// File: rtl/dac_spi_shifter.sv
// SCLK divider, frame shift register and half-period counter for one DAC frame.
module dac_spi_shifter
  import wave_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_load,
  input  logic                   i_run,
  input  logic [DAC_FRAME_W-1:0] i_frame,
  output logic                   o_sclk,
  output logic                   o_mosi,
  output logic                   o_last_c
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned HALF_W = $clog2(2 * DAC_FRAME_W);

  logic [DIV_W-1:0]       r_div;
  logic [HALF_W-1:0]      r_half;
  logic [DAC_FRAME_W-1:0] r_shift;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   w_tick;

  assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
  // Final half-period (SCLK high after the 16th rising edge) ends on this cycle.
  assign o_last_c = i_run && w_tick && (r_half == HALF_W'(2 * DAC_FRAME_W - 1));

  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;

  // Load presents the MSB at once; afterwards MOSI moves only on falling SCLK edges.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (i_load) begin
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= i_frame;
      r_sclk  <= 1'b0;
      r_mosi  <= i_frame[DAC_FRAME_W-1];
    end else if (i_run) begin
      if (w_tick) begin
        r_div  <= '0;
        r_half <= r_half + 1'b1;
        r_sclk <= ~r_sclk;
        if (o_last_c) begin
          r_mosi <= 1'b0;
        end else if (r_sclk) begin
          r_shift <= {r_shift[DAC_FRAME_W-2:0], 1'b0};
          r_mosi  <= r_shift[DAC_FRAME_W-2];
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_dac_reader.sv
// Per-voice wavetable reader: filters the NCO address, reads the RAM, streams samples to an SPI DAC.
module wave_dac_reader
  import wave_pkg::*;
#(
  parameter int unsigned          CLK_DIV    = 2,
  parameter int unsigned          GAP_CYCLES = 4,
  parameter logic [DAC_CMD_W-1:0] DAC_CONFIG = 4'h3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [WAVERAM_ADDR_W-1:0] i_waveram_address,
  wave_dac_reader_if.master         ram_if,
  output logic                      o_dac_cs_n,
  output logic                      o_dac_sclk,
  output logic                      o_dac_mosi,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  localparam int unsigned GAP_W = 8;

  state_t                    r_state;
  logic [WAVERAM_ADDR_W-1:0] r_addr_a;
  logic [WAVERAM_ADDR_W-1:0] r_addr_b;
  logic [WAVERAM_ADDR_W-1:0] r_ram_address;
  logic                      r_ram_read_enable;
  logic                      r_dac_cs_n;
  logic                      r_frame_done;
  logic                      r_busy;
  logic [GAP_W-1:0]          r_gap_count;

  logic                      w_addr_stable;
  logic                      w_shift_last;
  logic [DAC_FRAME_W-1:0]    w_frame;

  assign w_addr_stable = (r_addr_a == r_addr_b);
  assign w_frame       = {DAC_CONFIG, ram_if.ram_data};

  assign ram_if.ram_address     = r_ram_address;
  assign ram_if.ram_read_enable = r_ram_read_enable;
  assign o_dac_cs_n             = r_dac_cs_n;
  assign o_frame_done           = r_frame_done;
  assign o_busy                 = r_busy;

  // Two-stage address pipeline; pure data path, so it is left out of reset
  // and keeps tracking the NCO while reset is held.
  always_ff @(posedge i_clock) begin
    r_addr_a <= i_waveram_address;
    r_addr_b <= r_addr_a;
  end

  // Frame sequencer: capture, RAM read, DAC shift, inter-frame gap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state           <= IDLE;
      r_ram_address     <= '0;
      r_ram_read_enable <= 1'b0;
      r_dac_cs_n        <= 1'b1;
      r_frame_done      <= 1'b0;
      r_busy            <= 1'b0;
      r_gap_count       <= '0;
    end else begin
      r_ram_read_enable <= 1'b0;
      r_frame_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state <= CAPTURE;
            r_busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (w_addr_stable) begin
            r_ram_address     <= r_addr_b;
            r_ram_read_enable <= 1'b1;
            r_state           <= WAIT;
          end
        end
        WAIT: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_dac_cs_n <= 1'b0;
          r_state    <= SHIFT;
        end
        SHIFT: begin
          if (w_shift_last) begin
            r_dac_cs_n  <= 1'b1;
            r_gap_count <= '0;
            r_state     <= GAP;
          end
        end
        GAP: begin
          if (r_gap_count == GAP_W'(GAP_CYCLES - 1)) begin
            r_frame_done <= 1'b1;
            if (i_enable) begin
              r_state <= CAPTURE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_count <= r_gap_count + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Serialiser; loads on the LOAD->SHIFT edge while RAM data is valid.
  dac_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (r_state == LOAD),
    .i_run    (r_state == SHIFT),
    .i_frame  (w_frame),
    .o_sclk   (o_dac_sclk),
    .o_mosi   (o_dac_mosi),
    .o_last_c (w_shift_last)
  );

endmodule

// File: tb/tb_wave_dac_reader.sv
// Scoreboard bench: expected RAM addresses and DAC words are queued as stimulus is applied.
module tb_wave_dac_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        en1 = 1'b0, en2 = 1'b0;
  logic [12:0] addr1 = 13'h0A5, addr2 = 13'h000;
  logic        cs1, sclk1, mosi1, done1, busy1;
  logic        cs2, sclk2, mosi2, done2, busy2;

  wave_dac_reader_if ram_if1();
  wave_dac_reader_if ram_if2();

  wave_dac_reader u_dut1 (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_enable          (en1),
    .i_waveram_address (addr1),
    .ram_if            (ram_if1.master),
    .o_dac_cs_n        (cs1),
    .o_dac_sclk        (sclk1),
    .o_dac_mosi        (mosi1),
    .o_frame_done      (done1),
    .o_busy            (busy1)
  );

  wave_dac_reader #(.CLK_DIV(1), .GAP_CYCLES(1), .DAC_CONFIG(4'h3)) u_dut2 (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_enable          (en2),
    .i_waveram_address (addr2),
    .ram_if            (ram_if2.master),
    .o_dac_cs_n        (cs2),
    .o_dac_sclk        (sclk2),
    .o_dac_mosi        (mosi2),
    .o_frame_done      (done2),
    .o_busy            (busy2)
  );

  // Wavetable contents
  function automatic logic [11:0] ram_val(input logic [12:0] a);
    case (a)
      13'h0A5: return 12'h7FF;
      13'h010: return 12'h000;
      13'h011: return 12'hFFF;
      default: return a[11:0] ^ 12'h5A5;
    endcase
  endfunction

  // RAM models: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_if1.ram_read_enable === 1'b1) ram_if1.ram_data <= ram_val(ram_if1.ram_address);
    if (ram_if2.ram_read_enable === 1'b1) ram_if2.ram_data <= ram_val(ram_if2.ram_address);
  end

  // Which DUT the monitor watches
  logic        sel = 1'b0;
  logic        m_cs, m_sclk, m_mosi, m_done, m_strobe;
  logic [12:0] m_raddr;
  assign m_cs     = sel ? cs2 : cs1;
  assign m_sclk   = sel ? sclk2 : sclk1;
  assign m_mosi   = sel ? mosi2 : mosi1;
  assign m_done   = sel ? done2 : done1;
  assign m_strobe = sel ? ram_if2.ram_read_enable : ram_if1.ram_read_enable;
  assign m_raddr  = sel ? ram_if2.ram_address : ram_if1.ram_address;

  logic [12:0] exp_addr[$];
  logic [15:0] exp_word[$];
  int n_vec = 0, n_err = 0;

  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [15:0] mon_word = '0;
  logic [12:0] ea;
  logic [15:0] ew;
  int mon_bits = 0, mon_low = 0, done_cnt = 0, done_cyc = 0, strobe_cnt = 0, strobe_cyc = 0;
  int exp_low;

  // Output monitor: pops expectations on each strobe and each completed frame
  always @(negedge clk) begin
    if (rst) begin
      mon_bits = 0; mon_low = 0; mon_word = '0; prev_sclk = 1'b0; prev_cs = 1'b1;
    end else begin
      if (m_strobe === 1'b1) begin
        strobe_cnt++; strobe_cyc = cyc; n_vec++;
        if (exp_addr.size() == 0) begin
          n_err++; $display("FAIL strobe_addr: unexpected strobe at address %h", m_raddr);
        end else begin
          ea = exp_addr.pop_front();
          if (m_raddr !== ea) begin
            n_err++; $display("FAIL strobe_addr: got %h expected %h", m_raddr, ea);
          end
        end
      end
      if (m_cs === 1'b0) begin
        mon_low++;
        if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
          mon_word = {mon_word[14:0], m_mosi};
          mon_bits++;
        end
      end
      if (m_cs === 1'b1 && prev_cs === 1'b0) begin
        exp_low = sel ? 32 : 64;
        n_vec++;
        if (exp_word.size() == 0) begin
          n_err++; $display("FAIL dac_word: unexpected frame %h", mon_word);
        end else begin
          ew = exp_word.pop_front();
          if (mon_word !== ew || mon_bits != 16) begin
            n_err++; $display("FAIL dac_word: got %h (%0d bits) expected %h (16 bits)", mon_word, mon_bits, ew);
          end
        end
        n_vec++;
        if (mon_low != exp_low) begin
          n_err++; $display("FAIL cs_low_cycles: got %0d expected %0d", mon_low, exp_low);
        end
        mon_bits = 0; mon_low = 0; mon_word = '0;
      end
      if (m_done === 1'b1) begin
        done_cnt++; done_cyc = cyc;
      end
      prev_sclk = m_sclk; prev_cs = m_cs;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int limit);
    int t = 0;
    while (done_cnt < target && t < limit) begin tick(); t++; end
    if (done_cnt < target) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got %0d frame_done pulses expected %0d", done_cnt, target);
    end
  endtask

  task automatic wait_bits(input int target, input int limit);
    int t = 0;
    while (mon_bits < target && t < limit) begin tick(); t++; end
    if (mon_bits < target) begin
      n_vec++; n_err++;
      $display("FAIL bits_timeout: got %0d bits expected %0d", mon_bits, target);
    end
  endtask

  int rst_cyc, first_done;

  task automatic test_reset();
    addr1 = 13'h0A5; en1 = 1'b1; rst = 1'b1;
    tick(3);
    n_vec++; if (cs1 !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b expected 1", cs1); end
    n_vec++; if (sclk1 !== 1'b0) begin n_err++; $display("FAIL rst_sclk: got %b expected 0", sclk1); end
    n_vec++; if (mosi1 !== 1'b0) begin n_err++; $display("FAIL rst_mosi: got %b expected 0", mosi1); end
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    n_vec++; if (ram_if1.ram_read_enable !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b expected 0", ram_if1.ram_read_enable); end
    n_vec++; if (ram_if1.ram_address !== 13'h0) begin n_err++; $display("FAIL rst_address: got %h expected 0", ram_if1.ram_address); end
    // Enable stays high, so two frames of RAM[0x0A5] follow back to back
    exp_addr.push_back(13'h0A5); exp_word.push_back(16'h37FF);
    exp_addr.push_back(13'h0A5); exp_word.push_back(16'h37FF);
    rst = 1'b0; rst_cyc = cyc;
    tick();
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL capture_entry_busy: got %b expected 1", busy1); end
    tick();
    n_vec++; if (ram_if1.ram_read_enable !== 1'b1) begin n_err++; $display("FAIL first_strobe: got %b expected 1", ram_if1.ram_read_enable); end
  endtask

  task automatic test_basic_frame();
    wait_done(1, 200);
    // IDLE cycle + 71-cycle frame
    n_vec++; if (done_cyc - rst_cyc != 72) begin n_err++; $display("FAIL first_done_latency: got %0d expected 72", done_cyc - rst_cyc); end
    first_done = done_cyc;
    // Third frame, cut short by the disable test
    exp_addr.push_back(13'h0A5); exp_word.push_back(16'h37FF);
    wait_done(2, 200);
    n_vec++; if (done_cyc - first_done != 71) begin n_err++; $display("FAIL frame_period: got %0d expected 71", done_cyc - first_done); end
  endtask

  task automatic test_disable_mid_frame();
    int s0, cs_bad;
    wait_bits(5, 200);
    en1 = 1'b0;
    wait_done(3, 200);
    tick();
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL disable_busy: got %b expected 0", busy1); end
    s0 = strobe_cnt; cs_bad = 0;
    repeat (100) begin tick(); if (cs1 !== 1'b1) cs_bad++; end
    n_vec++; if (cs_bad != 0 || strobe_cnt != s0) begin n_err++; $display("FAIL disable_idle: got %0d cs_n-low cycles and %0d strobes expected 0 and 0", cs_bad, strobe_cnt - s0); end
  endtask

  task automatic test_unstable_address();
    int hold_cyc, s0, t;
    exp_addr.push_back(13'h1FFF); exp_word.push_back({4'h3, ram_val(13'h1FFF)});
    s0 = strobe_cnt;
    en1 = 1'b1;
    for (int i = 0; i < 10; i++) begin addr1 = 13'(i * 341 + 7); tick(); end
    addr1 = 13'h1FFF; hold_cyc = cyc;
    t = 0;
    while (strobe_cnt == s0 && t < 20) begin tick(); t++; end
    // Two cycles to fill both stages, then the registered strobe one cycle after acceptance
    n_vec++; if (strobe_cnt == s0 || strobe_cyc - hold_cyc != 3) begin n_err++; $display("FAIL unstable_strobe_delay: got %0d expected 3", strobe_cyc - hold_cyc); end
    en1 = 1'b0;
    wait_done(4, 200);
  endtask

  task automatic test_reset_mid_shift();
    int d0, cs_bad;
    addr1 = 13'h0A5; tick(3);
    exp_addr.push_back(13'h0A5);
    en1 = 1'b1;
    wait_bits(8, 200);
    rst = 1'b1; en1 = 1'b0;
    tick();
    n_vec++; if (cs1 !== 1'b1) begin n_err++; $display("FAIL midrst_cs_n: got %b expected 1", cs1); end
    n_vec++; if (sclk1 !== 1'b0) begin n_err++; $display("FAIL midrst_sclk: got %b expected 0", sclk1); end
    n_vec++; if (busy1 !== 1'b0 || mosi1 !== 1'b0) begin n_err++; $display("FAIL midrst_busy_mosi: got %b%b expected 00", busy1, mosi1); end
    d0 = done_cnt;
    tick(2); rst = 1'b0;
    cs_bad = 0;
    repeat (100) begin tick(); if (cs1 !== 1'b1) cs_bad++; end
    n_vec++; if (done_cnt != d0 || cs_bad != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d done pulses and %0d cs_n-low cycles expected 0 and 0", done_cnt - d0, cs_bad); end
  endtask

  task automatic test_back_to_back();
    int s0, d0, t, first;
    sel = 1'b1;
    addr2 = 13'h010; tick(3);
    exp_addr.push_back(13'h010); exp_word.push_back(16'h3000);
    exp_addr.push_back(13'h011); exp_word.push_back(16'h3FFF);
    s0 = strobe_cnt; d0 = done_cnt;
    en2 = 1'b1;
    t = 0;
    while (strobe_cnt == s0 && t < 20) begin tick(); t++; end
    addr2 = 13'h011;
    wait_done(d0 + 1, 100);
    first = done_cyc;
    en2 = 1'b0;
    wait_done(d0 + 2, 100);
    n_vec++; if (done_cyc - first != 36) begin n_err++; $display("FAIL b2b_period: got %0d expected 36", done_cyc - first); end
    tick(10);
    n_vec++; if (exp_addr.size() != 0 || exp_word.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d addr %0d words left expected 0 0", exp_addr.size(), exp_word.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_disable_mid_frame();
    test_unstable_address();
    test_reset_mid_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
